inst_loader: RTL and testbench
==============================

# inst_loader

Boot-time writer for the instruction memory that the fetch stage (PC, IR, condition check) reads. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and writes them to consecutive word addresses on the memory's write port. It verifies a trailing XOR checksum and holds the fetch stage frozen for the whole load.

## Interface
- DEPTH_LOG2, 6: word-address width; matches the fetch-side Inst_Addr[7:2] (64 words).
- clk  in  1  rising-edge clock.
- Rst  in  1  synchronous, active-low reset.
- Start  in  1  one-cycle request to begin a load; sampled only in IDLE.
- Byte_In  in  8  stream byte.
- Byte_Valid  in  1  Byte_In is valid.
- Byte_Ready  out  1  loader accepts a byte this cycle.
- Mem_We  out  1  instruction-memory write strobe.
- Mem_Addr  out  DEPTH_LOG2  word address, equivalent to byte address bits [7:2].
- Mem_Wdata  out  32  assembled word.
- Cpu_Hold  out  1  while high, the fetch stage's Write_PC and Write_IR are gated low.
- Busy  out  1  load in progress.
- Done  out  1  one-cycle pulse at the end of a load.
- Err  out  1  checksum mismatch on the last load; level, held until the next Start.

## Operation
- Byte transfer: a byte is accepted on a rising edge where Byte_Valid && Byte_Ready.
- Stream format: header byte N, then 4·N' data bytes, then one checksum byte.
  - N' = N, except N = 0 means 2^DEPTH_LOG2 (64).
  - Data bytes are little-endian within each word: the first byte goes to [7:0], the fourth to [31:24].
  - The checksum byte equals the XOR of the header and all data bytes.
- States:
  - IDLE: Byte_Ready=0. On Start, go to HDR; clear Err, word index, byte index and running XOR.
  - HDR: Byte_Ready=1. Accept N, XOR it into the checksum, go to DATA.
  - DATA: Byte_Ready=1. Each accepted byte is shifted into its lane and XORed into the checksum. On the 4th byte of a word, go to WRITE.
  - WRITE: Byte_Ready=0, Mem_We=1 for exactly one cycle, Mem_Addr = word index, Mem_Wdata = assembled word. Then increment the word index. If the written word was number N'−1, go to CSUM; otherwise go to DATA.
  - CSUM: Byte_Ready=1. Accept the byte and set Err = (byte != running XOR). Go to DONE.
  - DONE: Done=1 for one cycle, go to IDLE.
- Word index is DEPTH_LOG2+1 bits wide internally so that a count of 64 is representable. Mem_Addr is its low DEPTH_LOG2 bits, so the last address written is 63. It never wraps to 0 within a load.
- Busy=1 in every state except IDLE.
- Cpu_Hold rises on the edge that leaves IDLE and falls on the edge that leaves DONE, so it is high in DONE.
- Start while Busy is ignored.
- Stalls: Byte_Valid low for any number of cycles stalls the current state with no side effects.
- Err: retained after DONE until the next accepted Start or reset.
- Memory contents: words are written regardless of the checksum result. Err only flags the failure; the controller decides whether to release the CPU.

## Timing
- Reset (Rst=0 at an edge) gives State=IDLE, Byte_Ready=0, Mem_We=0, Mem_Addr=0, Mem_Wdata=0, Cpu_Hold=0, Busy=0, Done=0, Err=0, and all counters and the XOR cleared.
- Reset mid-load aborts on that edge. Words already written stay in memory, and Done does not pulse.
- Start at edge t: HDR from t+1, with Byte_Ready=1 in cycle t+1.
- 4th byte of a word accepted at edge t: Mem_We=1 during cycle t+1, and the write commits at edge t+2. Byte_Ready is low during cycle t+1 and returns high at t+2.
- Throughput with no stalls is 5 cycles per word.
- Minimum total load length is 1 + 5·N' + 1 + 1 cycles after Start (HDR, N' words, CSUM, DONE).
- Mem_Addr and Mem_Wdata are registered. They hold their last values outside WRITE, and are valid only while Mem_We=1.

## Test plan
- Start, then bytes 01, 78 56 34 12, checksum 01^78^56^34^12=0x09 → one write: Mem_Addr=0, Mem_Wdata=0x12345678. Then Done pulse, Err=0, Cpu_Hold low after DONE.
- Header 00 followed by 256 data bytes (word k = k) and the correct checksum → 64 writes at addresses 0..63, the last being address 63 with data 0x0000003F. No write to address 0 after 63, and Err=0.
- Same stream as the first scenario with checksum 0x00 → the word is still written, Done pulses, and Err=1 stays high until the next Start, which clears it.
- Byte_Valid toggled with random gaps of 0–5 cycles on a 3-word load → identical writes to the no-gap case, Byte_Ready=0 in every WRITE cycle, and no duplicated bytes.
- Start pulsed again during DATA → ignored; the load completes with the original N.
- Rst driven low after 2 of 3 words have been written → next cycle all outputs are at reset values and Done never pulses. A fresh Start then loads normally from address 0.

Source files
------------

// File: rtl/inst_loader.sv
// Boot-time instruction-memory loader: assembles a little-endian byte stream into
// 32-bit words, writes them to consecutive word addresses and checks an XOR checksum.
module inst_loader #(
  parameter int unsigned DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  Rst,
  input  logic                  Start,
  input  logic [7:0]            Byte_In,
  input  logic                  Byte_Valid,
  output logic                  Byte_Ready,
  output logic                  Mem_We,
  output logic [DEPTH_LOG2-1:0] Mem_Addr,
  output logic [31:0]           Mem_Wdata,
  output logic                  Cpu_Hold,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Err
);

  localparam int unsigned MAX_WORDS = 1 << DEPTH_LOG2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [DEPTH_LOG2:0]   r_word_idx;
  logic [DEPTH_LOG2:0]   r_nwords;
  logic [1:0]            r_byte_idx;
  logic [7:0]            r_xor;
  logic [23:0]           r_asm;
  logic                  r_err;
  logic                  w_accept;
  logic                  w_last_word;
  logic [DEPTH_LOG2:0]   w_hdr_words;

  assign w_accept    = Byte_Valid && Byte_Ready;
  assign w_last_word = ((r_word_idx + (DEPTH_LOG2+1)'(1)) == r_nwords);
  assign Err         = r_err;

  // Header 0 means a full memory; headers beyond the memory size are clamped to it
  // so the last-word compare always terminates inside the address range.
  assign w_hdr_words = ((Byte_In == '0) || (32'(Byte_In) > MAX_WORDS))
                     ? (DEPTH_LOG2+1)'(MAX_WORDS)
                     : (DEPTH_LOG2+1)'(Byte_In);

  always_ff @(posedge clk) begin
    if (!Rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    Byte_Ready = 1'b0;
    Mem_We     = 1'b0;
    Busy       = 1'b1;
    Cpu_Hold   = 1'b1;
    Done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        Busy     = 1'b0;
        Cpu_Hold = 1'b0;
        if (Start) begin
          w_next = S_HDR;
        end
      end
      S_HDR: begin
        Byte_Ready = 1'b1;
        if (Byte_Valid) begin
          w_next = S_DATA;
        end
      end
      S_DATA: begin
        Byte_Ready = 1'b1;
        if (Byte_Valid && (r_byte_idx == 2'd3)) begin
          w_next = S_WRITE;
        end
      end
      S_WRITE: begin
        Mem_We = 1'b1;
        w_next = w_last_word ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        Byte_Ready = 1'b1;
        if (Byte_Valid) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        Done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!Rst) begin
      r_word_idx <= '0;
      r_nwords   <= '0;
      r_byte_idx <= '0;
      r_xor      <= '0;
      r_asm      <= '0;
      r_err      <= 1'b0;
      Mem_Addr   <= '0;
      Mem_Wdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_err      <= 1'b0;
            r_word_idx <= '0;
            r_byte_idx <= '0;
            r_xor      <= '0;
          end
        end
        S_HDR: begin
          if (w_accept) begin
            r_nwords <= w_hdr_words;
            r_xor    <= r_xor ^ Byte_In;
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_xor      <= r_xor ^ Byte_In;
            r_byte_idx <= r_byte_idx + 2'd1;
            // First byte of a word shifts down to [7:0] after three more arrive.
            r_asm      <= {Byte_In, r_asm[23:8]};
            if (r_byte_idx == 2'd3) begin
              Mem_Addr  <= r_word_idx[DEPTH_LOG2-1:0];
              Mem_Wdata <= {Byte_In, r_asm};
            end
          end
        end
        S_WRITE: begin
          r_word_idx <= r_word_idx + (DEPTH_LOG2+1)'(1);
        end
        S_CSUM: begin
          if (w_accept) begin
            r_err <= (Byte_In != r_xor);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Directed table-driven bench for inst_loader: streams loads, logs memory writes
// and compares them, plus handshake/timing flags, against bench-computed values.
module tb_inst_loader;

  logic        clk = 1'b0;
  logic        Rst;
  logic        Start;
  logic [7:0]  Byte_In;
  logic        Byte_Valid;
  logic        Byte_Ready;
  logic        Mem_We;
  logic [5:0]  Mem_Addr;
  logic [31:0] Mem_Wdata;
  logic        Cpu_Hold;
  logic        Busy;
  logic        Done;
  logic        Err;

  inst_loader #(.DEPTH_LOG2(6)) dut (
    .clk       (clk),
    .Rst       (Rst),
    .Start     (Start),
    .Byte_In   (Byte_In),
    .Byte_Valid(Byte_Valid),
    .Byte_Ready(Byte_Ready),
    .Mem_We    (Mem_We),
    .Mem_Addr  (Mem_Addr),
    .Mem_Wdata (Mem_Wdata),
    .Cpu_Hold  (Cpu_Hold),
    .Busy      (Busy),
    .Done      (Done),
    .Err       (Err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  hdr;
    int          nw;
    logic [31:0] base;
    logic [31:0] step;
    logic [7:0]  corrupt;
    int          gap;
    bit          start_mid;
    bit          exp_err;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          cyc = 0;
  bit          prev_err = 1'b0;
  logic [5:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  vec_t        vecs[7];

  task automatic do_check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (Done) done_cnt++;
    if (Mem_We) begin
      wr_addr.push_back(Mem_Addr);
      wr_data.push_back(Mem_Wdata);
      do_check("ready_low_in_write", 32'(Byte_Ready), 32'd0);
    end
  end

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int n;
    n = 0;
    Byte_Valid = 1'b0;
    repeat ($urandom_range(0, max_gap)) @(negedge clk);
    Byte_In    = b;
    Byte_Valid = 1'b1;
    while (!Byte_Ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!Byte_Ready) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: got ready=0 expected ready=1 within 50 cycles");
    end
    @(negedge clk);
    Byte_Valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    do_check({tag, "_ready"}, 32'(Byte_Ready), 32'd0);
    do_check({tag, "_we"},    32'(Mem_We),     32'd0);
    do_check({tag, "_addr"},  32'(Mem_Addr),   32'd0);
    do_check({tag, "_wdata"}, Mem_Wdata,       32'd0);
    do_check({tag, "_hold"},  32'(Cpu_Hold),   32'd0);
    do_check({tag, "_busy"},  32'(Busy),       32'd0);
    do_check({tag, "_done"},  32'(Done),       32'd0);
    do_check({tag, "_err"},   32'(Err),        32'd0);
  endtask

  task automatic run_load(input vec_t v);
    logic [7:0]  x;
    logic [31:0] w;
    int          t0;
    int          n;
    int          d0;
    wr_addr.delete();
    wr_data.delete();
    d0 = done_cnt;
    if (prev_err) do_check("err_held_idle", 32'(Err), 32'd1);
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    t0 = cyc;
    do_check("hdr_ready", 32'(Byte_Ready), 32'd1);
    do_check("hdr_busy",  32'(Busy),       32'd1);
    do_check("hdr_hold",  32'(Cpu_Hold),   32'd1);
    do_check("err_clear_on_start", 32'(Err), 32'd0);
    x = v.hdr;
    send_byte(v.hdr, v.gap);
    for (int k = 0; k < v.nw; k++) begin
      w = v.base + 32'(k) * v.step;
      if (v.start_mid && k == 0) Start = 1'b1;
      for (int b = 0; b < 4; b++) begin
        x ^= w[8*b +: 8];
        send_byte(w[8*b +: 8], v.gap);
      end
      Start = 1'b0;
    end
    send_byte(x ^ v.corrupt, v.gap);
    n = 0;
    while (!Done && n < 10) begin
      @(negedge clk);
      n++;
    end
    do_check("done_pulse",   32'(Done),     32'd1);
    if (v.gap == 0) do_check("load_cycles", 32'(cyc - t0), 32'(2 + 5 * v.nw));
    do_check("hold_in_done", 32'(Cpu_Hold), 32'd1);
    do_check("err_in_done",  32'(Err),      32'(v.exp_err));
    @(negedge clk);
    do_check("done_one_cycle", 32'(Done),     32'd0);
    do_check("idle_busy",      32'(Busy),     32'd0);
    do_check("idle_hold",      32'(Cpu_Hold), 32'd0);
    do_check("err_after_done", 32'(Err),      32'(v.exp_err));
    do_check("done_count",     32'(done_cnt - d0), 32'd1);
    do_check("write_count",    32'(wr_addr.size()), 32'(v.nw));
    for (int k = 0; k < v.nw && k < wr_addr.size(); k++) begin
      do_check("wr_addr", 32'(wr_addr[k]), 32'(k));
      do_check("wr_data", wr_data[k], v.base + 32'(k) * v.step);
    end
    prev_err = v.exp_err;
  endtask

  initial begin
    int d0;
    vecs[0] = '{8'h01, 1,  32'h12345678, 32'h00000000, 8'h00, 0, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 64, 32'h00000000, 32'h00000001, 8'h00, 0, 1'b0, 1'b0};
    vecs[2] = '{8'h01, 1,  32'h12345678, 32'h00000000, 8'h09, 0, 1'b0, 1'b1};
    vecs[3] = '{8'h03, 3,  32'hA5A50F0F, 32'h01020304, 8'h00, 0, 1'b0, 1'b0};
    vecs[4] = '{8'h03, 3,  32'hA5A50F0F, 32'h01020304, 8'h00, 5, 1'b0, 1'b0};
    vecs[5] = '{8'h02, 2,  32'hDEADBEEF, 32'h11111111, 8'h00, 0, 1'b1, 1'b0};
    vecs[6] = '{8'h02, 2,  32'h00FF00FF, 32'h10000001, 8'h80, 2, 1'b0, 1'b1};

    Rst        = 1'b0;
    Start      = 1'b0;
    Byte_In    = 8'h00;
    Byte_Valid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    Rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_load(vecs[i]);
      repeat (3) @(negedge clk);
    end

    // Abort a 3-word load after two words are in memory.
    wr_addr.delete();
    wr_data.delete();
    d0 = done_cnt;
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    send_byte(8'h03, 0);
    for (int b = 0; b < 8; b++) send_byte(8'(b + 1), 0);
    @(negedge clk);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    Rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midload_reset");
    @(negedge clk);
    Rst = 1'b1;
    repeat (4) @(negedge clk);
    do_check("abort_no_done",     32'(done_cnt - d0), 32'd0);
    do_check("abort_write_count", 32'(wr_addr.size()), 32'd2);
    if (wr_data.size() == 2) begin
      do_check("abort_w0", wr_data[0], 32'h04030201);
      do_check("abort_w1", wr_data[1], 32'h08070605);
    end
    prev_err = 1'b0;
    run_load(vecs[3]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
